key_expand: RTL and testbench
=============================

Name: key_expand

Overview:
- AES-128 key schedule sequencer. It sits directly downstream of the rcon ROM: it drives the ROM address and consumes its registered 32-bit output.
- It expands one 128-bit cipher key into 11 round keys (rounds 0..10) and streams them one at a time to the round datapath with a valid strobe.
- It is iterative: one 4-word expansion step per round, sharing a single SubWord unit.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; it sets the final round index.
- KW, 128, key width in bits. Fixed at 4 words of 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request expansion. Sampled only in IDLE.
- key_in  in  128  cipher key, word 0 in bits [127:96]. Captured on the accepted start.
- rcon_addr  out  4  address to rcon ROM. Always in range 0..10.
- rcon_din  in  32  rcon ROM dout. Valid one cycle after address is sampled. Rcon byte in [31:24], [23:0] zero.
- round_key  out  128  current round key, word 0 in [127:96]
- round_idx  out  4  round number of round_key, 0..10
- round_key_valid  out  1  one-cycle pulse when round_key/round_idx are new
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse coincident with round 10 valid

Behaviour:
- Reset (async assert, sync release): state IDLE. All of the following are 0: round_key, round_idx, round_key_valid, busy, done, rcon_addr, and the internal round counter r.
- States: IDLE, FETCH, CALC.
- IDLE:
  - start=1 registers key_in into round_key and sets round_idx=0, round_key_valid=1, busy=1, r=1, then goes to FETCH.
  - start=0 holds state.
- FETCH:
  - rcon_addr = r, driven from the registered counter.
  - The ROM samples the address at the end of this cycle.
  - Goes to CALC.
- CALC:
  - rcon_din now holds Rcon[r].
  - Computes, with w0..w3 = current round_key words:
    - t = SubWord(RotWord(w3)) xor rcon_din
    - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - Registers {n0,n1,n2,n3} into round_key, sets round_idx=r and round_key_valid=1.
  - If r==NR: done=1 and go to IDLE, clearing busy on the same edge. Otherwise r=r+1 and go to FETCH.
- RotWord: byte rotate left, {b1,b2,b3,b0}.
- SubWord: the AES S-box applied to each byte.
- round_key_valid and done are high for exactly one cycle each. round_key holds its value between pulses and after done.
- Latency:
  - Start accepted at edge 0. Round 0 valid in cycle 1.
  - Round k valid in cycle 2k+1. Round 10 and done in cycle 21.
  - Next start accepted in cycle 21 (state IDLE); back-to-back restart is allowed.
- start while busy: ignored. key_in changes while busy have no effect.
- start held high continuously: a new expansion begins each time IDLE is reached.
- No downstream backpressure: the consumer must capture each key on round_key_valid.
- rcon_addr holds its last value in IDLE. It never exceeds NR, so ROM addresses 11..15 are never used.
- Reset mid-expansion: immediate return to IDLE with all outputs 0. No done pulse.

Decomposition:
- Shared package aes_pkg:
  - NR=10, NK=4, WORD_W=32.
  - State encoding constants ST_IDLE, ST_FETCH, ST_CALC.
  - Function rot_word.
- Sub-module sub_word: combinational 32-bit SubWord built from four byte S-box lookups (S-box table as a case/ROM). This is the only natural split; the FSM, counter and XOR chain stay in key_expand.
- The bench instantiates key_expand together with the real rcon ROM. rcon.dat holds addr 1..10 = 01,02,04,08,10,20,40,80,1b,36 in [31:24]; addr 0 = 0.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - Round 0 echoes the key in cycle 1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605 in cycle 3.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 21 with done=1.
  - Exactly 11 valid pulses; busy=0 afterward.
- All-zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Assert start plus a different key_in during cycles 2..20 of a run: output sequence identical to the undisturbed run.
- Assert rst at cycle 9 of a run: all outputs go 0 immediately, no done, state IDLE. A new start then yields the correct 11-key sequence from round 0.
- Hold start=1 across two runs with keys A then B (key_in switched to B before cycle 21): run B starts at cycle 21, its round 0 is valid in cycle 22, and both runs match their reference schedules.
- Monitor rcon_addr over a full run: sequence 1..10, one value per FETCH, never 0 or above 10 while busy.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule sequencer.
//   NR      : number of rounds (AES-128 only, so 10)
//   NK      : key length in 32-bit words
//   WORD_W  : word width
//   state_t : key_expand sequencer states (ST_IDLE, ST_FETCH, ST_CALC)
//   rot_word: cyclic left byte rotation {b1,b2,b3,b0}
package aes_pkg;

  localparam int NR     = 10;
  localparam int NK     = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[WORD_W-9:0], w[WORD_W-1:WORD_W-8]};
  endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational AES SubWord: the forward S-box applied to each of the
// four bytes of a 32-bit word.
//   din  : input word
//   dout : substituted word (byte lanes preserved)
module sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // S-box table flattened row-major, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b); 255-b is simply ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule sequencer. Expands one cipher key into round keys
// 0..10, one 4-word expansion step per round through a shared SubWord unit,
// fetching Rcon from an external registered ROM.
//   clk, rst        : clock, asynchronous active-high reset
//   start, key_in   : expansion request and cipher key (word 0 in [127:96]),
//                     sampled only in IDLE
//   rcon_addr       : ROM address, equal to the round counter during FETCH
//   rcon_din        : ROM data, one cycle after the address is sampled
//   round_key       : current round key, round_idx its round number
//   round_key_valid : one-cycle pulse when round_key/round_idx are new
//   busy            : accepted start until round 10 is delivered
//   done            : one-cycle pulse together with round 10
//
// Handshake: there is no backpressure. Each round key is valid for exactly
// the one cycle round_key_valid is high and must be captured then; round_key
// itself holds until the next pulse. start is a level request looked at
// only in IDLE, so a held start restarts as soon as a run finishes.
module key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [3:0]   rcon_addr,
  input  logic [31:0]  rcon_din,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         round_key_valid,
  output logic         busy,
  output logic         done
);

  state_t      state;
  logic [3:0]  r;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sw, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign rot = rot_word(w3);

  sub_word u_sub_word (
    .din  (rot),
    .dout (sw)
  );

  // rcon_din is only meaningful in CALC; the chain below is consumed only there.
  assign t  = sw ^ rcon_din;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      r               <= 4'd0;
      rcon_addr       <= 4'd0;
      round_key       <= 128'd0;
      round_idx       <= 4'd0;
      round_key_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      round_key_valid <= 1'b0;
      done            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            round_key       <= key_in;
            round_idx       <= 4'd0;
            round_key_valid <= 1'b1;
            busy            <= 1'b1;
            r               <= 4'd1;
            // Address is registered alongside r so the ROM sees it in FETCH.
            rcon_addr       <= 4'd1;
            state           <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_CALC;
        end
        ST_CALC: begin
          round_key       <= {n0, n1, n2, n3};
          round_idx       <= r;
          round_key_valid <= 1'b1;
          if (r == 4'(NR)) begin
            // Final round: rcon_addr keeps NR while idle.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            r         <= r + 4'd1;
            rcon_addr <= r + 4'd1;
            state     <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand with a registered Rcon ROM and a reference key
// schedule built from GF(2^8) arithmetic.
module tb_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = 128'd0;
  logic [3:0]   rcon_addr;
  logic [31:0]  rcon_din;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         round_key_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] ref_ks [11];
  logic [127:0] got_ks [11];
  logic [127:0] exp_q [$];

  logic [31:0] rom [16] = '{32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
                            32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
                            32'h80000000, 32'h1b000000, 32'h36000000, 32'h00000000,
                            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

  always #5 clk = ~clk;

  // Registered Rcon ROM.
  always @(posedge clk) rcon_din <= rom[rcon_addr];

  key_expand dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .key_in          (key_in),
    .rcon_addr       (rcon_addr),
    .rcon_din        (rcon_din),
    .round_key       (round_key),
    .round_idx       (round_idx),
    .round_key_valid (round_key_valid),
    .busy            (busy),
    .done            (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  // S-box from first principles: multiplicative inverse (b^254) then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic compute_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= 10; k++) ref_ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present start with key at the next negedge; returns right after the
  // accepting edge (edge 0 of the run).
  task automatic kick(input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
  endtask

  // Checks cycles 1..21 of a run whose start was accepted at the last edge.
  // mode 0: start low; mode 1: start high with random key_in in cycles 2..20;
  // mode 2: start held high, key_in switched to next_key from cycle 10.
  task automatic expect_run(input string name, input logic [127:0] key, input int mode,
                            input logic [127:0] next_key);
    int pulses;
    int k;
    logic [127:0] e;
    compute_ref(key);
    exp_q.delete();
    for (int i = 0; i <= 10; i++) exp_q.push_back(ref_ks[i]);
    pulses = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      chk($sformatf("%s valid c%0d", name, c), 128'(round_key_valid), 128'((c % 2) == 1));
      chk($sformatf("%s done c%0d", name, c), 128'(done), 128'(c == 21));
      chk($sformatf("%s busy c%0d", name, c), 128'(busy), 128'(c < 21));
      if (c < 21) begin
        chk($sformatf("%s rcon_addr range c%0d", name, c),
            128'(rcon_addr >= 4'd1 && rcon_addr <= 4'd10), 128'd1);
        if (c % 2 == 1)
          chk($sformatf("%s rcon_addr fetch c%0d", name, c), 128'(rcon_addr), 128'((c + 1) / 2));
      end else begin
        chk($sformatf("%s rcon_addr idle hold", name), 128'(rcon_addr), 128'd10);
      end
      if (round_key_valid) begin
        pulses++;
        k = (c - 1) / 2;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk($sformatf("%s key r%0d", name, k), round_key, e);
        chk($sformatf("%s idx r%0d", name, k), 128'(round_idx), 128'(k));
        got_ks[k] = round_key;
      end else if (c > 1) begin
        chk($sformatf("%s key hold c%0d", name, c), round_key, ref_ks[(c - 2) / 2]);
      end
      case (mode)
        1: begin
          if (c >= 2 && c <= 20) begin
            start  = 1'b1;
            key_in = rand_key();
          end else begin
            start = 1'b0;
          end
        end
        2: begin
          start  = 1'b1;
          key_in = (c >= 10) ? next_key : key;
        end
        default: start = 1'b0;
      endcase
    end
    chk($sformatf("%s pulse count", name), 128'(pulses), 128'd11);
  endtask

  task automatic check_idle(input string name, input int cycles, input logic [127:0] hold_key);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk($sformatf("%s idle valid", name), 128'(round_key_valid), 128'd0);
      chk($sformatf("%s idle busy", name), 128'(busy), 128'd0);
      chk($sformatf("%s idle done", name), 128'(done), 128'd0);
      chk($sformatf("%s idle key", name), round_key, hold_key);
    end
  endtask

  task automatic check_zero(input string name);
    chk($sformatf("%s round_key", name), round_key, 128'd0);
    chk($sformatf("%s round_idx", name), 128'(round_idx), 128'd0);
    chk($sformatf("%s valid", name), 128'(round_key_valid), 128'd0);
    chk($sformatf("%s busy", name), 128'(busy), 128'd0);
    chk($sformatf("%s done", name), 128'(done), 128'd0);
    chk($sformatf("%s rcon_addr", name), 128'(rcon_addr), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] ka;
    logic [127:0] kb;

    // Power-on reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1 check_zero("por");
    @(negedge clk);
    rst = 1'b0;
    check_idle("post_por", 2, 128'd0);

    // FIPS-197 key.
    kick(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expect_run("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'd0);
    chk("fips r0 echo", got_ks[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips r1 vector", got_ks[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips r10 vector", got_ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_idle("fips", 3, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key.
    kick(128'd0);
    expect_run("zero", 128'd0, 0, 128'd0);
    chk("zero r1 vector", got_ks[1], 128'h62636363626363636263636362636363);
    chk("zero r10 vector", got_ks[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start and key_in disturbed while busy.
    ka = rand_key();
    kick(ka);
    expect_run("disturb", ka, 1, 128'd0);

    // Reset in cycle 9 of a run.
    ka = rand_key();
    kick(ka);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    check_idle("after_reset", 3, 128'd0);
    kb = rand_key();
    kick(kb);
    expect_run("restart", kb, 0, 128'd0);

    // start held high across two runs, key switched to B mid-run A.
    ka = rand_key();
    kb = rand_key();
    kick(ka);
    expect_run("hold_a", ka, 2, kb);
    expect_run("hold_b", kb, 0, 128'd0);

    // Random keys, back to back with a start pulse each.
    for (int i = 0; i < 4; i++) begin
      ka = rand_key();
      kick(ka);
      expect_run($sformatf("rand%0d", i), ka, 0, 128'd0);
    end
    check_idle("final", 2, ref_ks[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
